// File: rtl/tap_window_buffer_pkg.sv
// Shared definitions for the tap window buffer: controller states and default geometry.
package tap_window_buffer_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_TAPS   = 32;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    IDLE   = 2'd1,
    STREAM = 2'd2
  } state_e;

endpackage

// File: rtl/tap_window_buffer_tap_ram.sv
// History RAM: one write port, one registered read port with write-first bypass.
// The read register has a synchronous clear so the tap output starts at zero.
module tap_ram
  import tap_window_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_TAPS,
  parameter int W     = DEFAULT_DATA_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  input  logic          rclr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // A sample written and read in the same cycle must appear on the very next cycle.
  always_ff @(posedge clk) begin
    if (rclr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      if (we_i && (waddr_i == raddr_i)) begin
        rdata_q <= wdata_i;
      end else begin
        rdata_q <= mem[raddr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tap_window_buffer.sv
// Delay-line window buffer sitting between the audio codec (sample_end/audio_input)
// and the LMS MAC: each accepted sample streams the TAPS newest samples, newest first.
module tap_window_buffer
  import tap_window_buffer_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int TAPS   = DEFAULT_TAPS
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sample_valid,
  input  logic [DATA_W-1:0]       sample_in,
  output logic                    busy,
  output logic                    tap_valid,
  input  logic                    tap_ready,
  output logic [DATA_W-1:0]       tap_data,
  output logic [$clog2(TAPS)-1:0] tap_index,
  output logic                    tap_last,
  output logic                    sample_drop
);

  localparam int IW = $clog2(TAPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IW-1:0] rd_ptr_q, rd_ptr_d;
  logic [IW-1:0] clr_addr_q, clr_addr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          drop_q, drop_d;

  logic              ram_we;
  logic [IW-1:0]     ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_re;
  logic [IW-1:0]     ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    clr_addr_d = clr_addr_q;
    idx_d      = idx_q;
    drop_d     = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = clr_addr_q;
    ram_wdata  = '0;
    ram_re     = 1'b0;
    ram_raddr  = rd_ptr_q;

    case (state_q)
      CLEAR: begin
        ram_we     = 1'b1;
        clr_addr_d = clr_addr_q + 1'b1;
        drop_d     = sample_valid;
        if (clr_addr_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (sample_valid) begin
          ram_we    = 1'b1;
          ram_waddr = wr_ptr_q;
          ram_wdata = sample_in;
          ram_re    = 1'b1;
          ram_raddr = wr_ptr_q;
          rd_ptr_d  = wr_ptr_q;
          wr_ptr_d  = wr_ptr_q + 1'b1;
          idx_d     = '0;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        drop_d = sample_valid;
        if (tap_ready) begin
          rd_ptr_d = rd_ptr_q - 1'b1;
          idx_d    = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            // Prefetch the next-older entry so it is on tap_data next cycle.
            ram_re    = 1'b1;
            ram_raddr = rd_ptr_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      clr_addr_q <= '0;
      idx_q      <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      clr_addr_q <= clr_addr_d;
      idx_q      <= idx_d;
      drop_q     <= drop_d;
    end
  end

  tap_ram #(
    .DEPTH (TAPS),
    .W     (DATA_W),
    .AW    (IW)
  ) u_tap_ram (
    .clk     (clk),
    .we_i    (ram_we & reset_n),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re & reset_n),
    .raddr_i (ram_raddr),
    .rclr_i  (~reset_n),
    .rdata_o (ram_rdata)
  );

  assign busy        = (state_q != IDLE);
  assign tap_valid   = (state_q == STREAM);
  assign tap_last    = (state_q == STREAM) && (idx_q == LAST_IDX);
  assign tap_data    = ram_rdata;
  assign tap_index   = idx_q;
  assign sample_drop = drop_q;

endmodule

// File: tb/tb_tap_window_buffer.sv
// Scoreboard bench for tap_window_buffer with TAPS=4, DATA_W=16.
module tb_tap_window_buffer;

  localparam int DW = 16;
  localparam int T  = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sample_valid;
  logic [DW-1:0] sample_in;
  logic          busy;
  logic          tap_valid;
  logic          tap_ready;
  logic [DW-1:0] tap_data;
  logic [1:0]    tap_index;
  logic          tap_last;
  logic          sample_drop;

  always #5 clk = ~clk;

  tap_window_buffer #(.DATA_W(DW), .TAPS(T)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .busy         (busy),
    .tap_valid    (tap_valid),
    .tap_ready    (tap_ready),
    .tap_data     (tap_data),
    .tap_index    (tap_index),
    .tap_last     (tap_last),
    .sample_drop  (sample_drop)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    idx;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] past[$];
  int            total  = 0;
  int            bad    = 0;
  int            hs_cnt = 0;

  exp_t          e;
  logic          held = 1'b0;
  logic [DW-1:0] h_data;
  logic [1:0]    h_idx;
  logic          h_last;

  // Handshake monitor: pops the scoreboard per accepted tap and checks stalls hold.
  always @(negedge clk) begin
    if (held && tap_valid && reset_n) begin
      total++;
      if ({tap_data, tap_index, tap_last} !== {h_data, h_idx, h_last}) begin
        bad++;
        $display("FAIL hold: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                 tap_data, tap_index, tap_last, h_data, h_idx, h_last);
      end
    end
    held = 1'b0;
    if (reset_n && tap_valid && !tap_ready) begin
      held   = 1'b1;
      h_data = tap_data;
      h_idx  = tap_index;
      h_last = tap_last;
    end
    if (reset_n && tap_valid && tap_ready) begin
      hs_cnt++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_tap: got data=%h idx=%0d want no tap", tap_data, tap_index);
      end else begin
        e = sb.pop_front();
        if ({tap_data, tap_index, tap_last} !== {e.data, e.idx, e.last}) begin
          bad++;
          $display("FAIL tap: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                   tap_data, tap_index, tap_last, e.data, e.idx, e.last);
        end else begin
          $display("tap data=%h idx=%0d last=%b", tap_data, tap_index, tap_last);
        end
      end
    end
  end

  task automatic push_window();
    exp_t x;
    for (int k = 0; k < T; k++) begin
      x.data = (k < past.size()) ? past[k] : '0;
      x.idx  = 2'(k);
      x.last = (k == T - 1);
      sb.push_back(x);
    end
  endtask

  // Called at posedge+1 while the DUT is idle; returns at posedge+1 of cycle n+1.
  task automatic drive_sample(input logic [DW-1:0] d, input bit accept);
    sample_in    = d;
    sample_valid = 1'b1;
    if (accept) begin
      past.push_front(d);
      if (past.size() > T) void'(past.pop_back());
      push_window();
    end
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (!tap_valid && sb.size() == 0) break;
    end
    total++;
    if (i >= 100) begin
      bad++;
      $display("FAIL %s_timeout: got pending=%0d want 0", name, sb.size());
    end
  endtask

  task automatic apply_reset();
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    tap_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    past.delete();
  endtask

  task automatic test_reset();
    int n;
    sample_in = '0;
    apply_reset();
    total += 6;
    if (busy !== 1'b1)      begin bad++; $display("FAIL rst_busy: got %b want 1", busy); end
    if (tap_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", tap_valid); end
    if (tap_last !== 1'b0)  begin bad++; $display("FAIL rst_last: got %b want 0", tap_last); end
    if (tap_data !== '0)    begin bad++; $display("FAIL rst_data: got %h want 0", tap_data); end
    if (tap_index !== '0)   begin bad++; $display("FAIL rst_index: got %0d want 0", tap_index); end
    if (sample_drop !== 1'b0) begin bad++; $display("FAIL rst_drop: got %b want 0", sample_drop); end
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    total += 2;
    if (n != T) begin bad++; $display("FAIL clear_len: got %0d want %0d", n, T); end
    if (tap_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL clear_end: got busy=%b valid=%b want 0 0", busy, tap_valid);
    end
    $display("reset: clear cycles=%0d", n);
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    tap_ready = 1'b1;
    drive_sample(16'h0011, 1'b1);
    total++;
    if (tap_valid !== 1'b1 || tap_index !== 2'd0 || tap_data !== 16'h0011) begin
      bad++;
      $display("FAIL latency: got valid=%b idx=%0d data=%h want 1 0 0011", tap_valid, tap_index, tap_data);
    end
    wait_idle("single");
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_busy: got %b want 0", busy); end
  endtask

  task automatic test_wrap();
    tap_ready = 1'b1;
    for (int v = 1; v <= 5; v++) begin
      drive_sample(DW'(v), 1'b1);
      wait_idle("wrap");
    end
  endtask

  task automatic test_backpressure();
    int  hs0;
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    hs0 = hs_cnt;
    tap_ready = 1'b1;
    drive_sample(16'h0A0A, 1'b1);
    for (int c = 0; c < 40; c++) begin
      tap_ready = pat[c % 4];
      @(posedge clk); #1;
      if (!tap_valid) break;
    end
    total++;
    if (hs_cnt - hs0 != T) begin
      bad++; $display("FAIL bp_count: got %0d want %0d", hs_cnt - hs0, T);
    end
    tap_ready = 1'b1;
    wait_idle("bp");
  endtask

  task automatic test_drop();
    tap_ready = 1'b1;
    drive_sample(16'h00A1, 1'b1);
    @(posedge clk); #1;
    sample_in = 16'hDEAD; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    total++;
    if (sample_drop !== 1'b1) begin bad++; $display("FAIL drop_stream: got %b want 1", sample_drop); end
    @(posedge clk); #1;
    total += 2;
    if (sample_drop !== 1'b0) begin bad++; $display("FAIL drop_pulse: got %b want 0", sample_drop); end
    if (tap_last !== 1'b1)    begin bad++; $display("FAIL drop_last: got %b want 1", tap_last); end
    sample_in = 16'hBEEF; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    total += 2;
    if (sample_drop !== 1'b1) begin bad++; $display("FAIL drop_final: got %b want 1", sample_drop); end
    if (tap_valid !== 1'b0)   begin bad++; $display("FAIL drop_idle: got %b want 0", tap_valid); end
    wait_idle("drop");
    drive_sample(16'h0042, 1'b1);
    wait_idle("drop_next");
  endtask

  task automatic test_reset_mid();
    int i;
    tap_ready = 1'b1;
    drive_sample(16'h0033, 1'b1);
    for (i = 0; i < 10; i++) begin
      if (tap_valid && tap_index == 2'd2) break;
      @(posedge clk); #1;
    end
    total++;
    if (i >= 10) begin bad++; $display("FAIL mid_find: got timeout want idx 2"); end
    reset_n   = 1'b0;
    tap_ready = 1'b0;
    @(posedge clk); #1;
    total += 3;
    if (tap_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", tap_valid); end
    if (busy !== 1'b1)      begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
    if (sb.size() != 2)     begin bad++; $display("FAIL mid_abort: got %0d pending want 2", sb.size()); end
    sb.delete();
    past.delete();
    reset_n      = 1'b1;
    sample_in    = 16'h0099;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    total++;
    if (sample_drop !== 1'b1) begin bad++; $display("FAIL drop_clear: got %b want 1", sample_drop); end
    for (i = 0; i < 10; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    total++;
    if (i >= 10) begin bad++; $display("FAIL mid_clear: got busy=%b want 0", busy); end
    tap_ready = 1'b1;
    drive_sample(16'h0007, 1'b1);
    wait_idle("mid_next");
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tap_window_buffer.md
TAP_WINDOW_BUFFER -- requirements
Module: tap_window_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width in bits (signed two's complement).
REQ-002 SHALL have parameter TAPS, default 32, window length; power of two, 2..256.
REQ-003 SHALL have port clk  input  1  single clock (main_clk domain); one clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port sample_valid  input  1  one-cycle strobe: new input sample present.
REQ-006 SHALL have port sample_in  input  DATA_W  new input sample, qualified by sample_valid.
REQ-007 SHALL have port busy  output  1  high while clearing or streaming.
REQ-008 SHALL have port tap_valid  output  1  tap_data/tap_index/tap_last valid.
REQ-009 SHALL have port tap_ready  input  1  downstream LMS MAC accepts the current tap.
REQ-010 SHALL have port tap_data  output  DATA_W  delayed sample x[n-k].
REQ-011 SHALL have port tap_index  output  $clog2(TAPS)  k, 0 = newest.
REQ-012 SHALL have port tap_last  output  1  high with k = TAPS-1.
REQ-013 SHALL have port sample_drop  output  1  one-cycle pulse: sample_valid ignored.

Function
REQ-014 SHALL implement FSM CLEAR, IDLE, STREAM.
REQ-015 CLEAR: write 0 to one entry per cycle, addresses 0..TAPS-1, then enter IDLE; duration exactly TAPS cycles; busy=1.
REQ-016 IDLE: busy=0, tap_valid=0; on sample_valid write sample_in to mem[wr_ptr], load rd_ptr=wr_ptr, wr_ptr+1 mod TAPS, tap_index=0, enter STREAM.
REQ-017 Latency: sample_valid accepted in cycle n SHALL give tap_valid=1 in cycle n+1 with tap_data = that sample, tap_index=0.
REQ-018 STREAM: tap_valid=1 and busy=1; tap_data = mem[rd_ptr], reflecting the write made on entry.
REQ-019 Handshake: advance only when tap_valid & tap_ready; then rd_ptr-1 mod TAPS (wrap TAPS-1 after 0), tap_index+1.
REQ-020 With tap_ready=0, tap_data/tap_index/tap_last SHALL hold stable.
REQ-021 Handshake with tap_last=1 SHALL return to IDLE; tap_valid=0 the next cycle.
REQ-022 Exactly TAPS handshakes per accepted sample; order newest to oldest.
REQ-023 sample_valid in CLEAR or STREAM, including the cycle of the final handshake, SHALL be dropped: no write, no pointer change, sample_drop=1 next cycle.
REQ-024 Not-yet-written history entries SHALL read as 0.
REQ-025 No arithmetic on sample values; data passes bit-exact.

Reset
REQ-026 reset_n=0 at a rising edge SHALL, next cycle: state=CLEAR, wr_ptr=0, rd_ptr=0, clear address=0, tap_index=0, tap_valid=0, tap_last=0, tap_data=0, sample_drop=0, busy=1.
REQ-027 Reset mid-STREAM SHALL abort the window with no further handshakes; history cleared via CLEAR.
REQ-028 Memory SHALL not depend on reset for clearing; CLEAR performs it.

Structure
REQ-029 A shared package SHALL hold the state enum (CLEAR, IDLE, STREAM) and default DATA_W/TAPS constants.
REQ-030 History storage SHALL be one sub-module, tap_ram: single-port-write, async-or-registered-read RAM, depth TAPS, width DATA_W, inferable as MLAB/M10K.
REQ-031 Top-level SHALL instantiate it between audio_codec (sample_end -> sample_valid, audio_input -> sample_in) and LMS.

Verification (TAPS=4, DATA_W=16)
REQ-032 Reset, then idle -> busy=1 exactly 4 cycles, then busy=0, tap_valid=0.
REQ-033 After clear, sample 0x0011, tap_ready=1 -> tap_valid cycles n+1..n+4, data 0x0011,0,0,0, index 0..3, tap_last on index 3.
REQ-034 Samples 1,2,3,4,5, each after its window -> window for 5 = 5,4,3,2 (wrap verified).
REQ-035 tap_ready toggled 1,0,0,1,... -> outputs hold on 0 cycles; 4 handshakes total; same data order.
REQ-036 sample_valid during STREAM and on last-handshake cycle -> sample_drop pulse each; next window unchanged.
REQ-037 reset_n=0 at index 2 -> tap_valid=0 next cycle; CLEAR; next window 0x0007,0,0,0.
